// File: rtl/jram_sp_if.sv
// rtl/jram_sp_if.sv - access/bus-emulation signal bundle for jram_sp
interface jram_sp_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   localparam int NB = DW / 8;

   logic          cen;
   logic          rw;
   logic [NB-1:0] be;
   logic          clr;
   logic [AW-1:0] a;
   logic [DW-1:0] z_in;
   logic [DW-1:0] z_out;
   logic [DW-1:0] z_oe;
   logic          busy;

   modport master (
      output cen, rw, be, clr, a, z_in,
      input  z_out, z_oe, busy
   );

   modport slave (
      input  cen, rw, be, clr, a, z_in,
      output z_out, z_oe, busy
   );
endinterface

// File: rtl/jram_sp.sv
// rtl/jram_sp.sv - single-port RAM with byte enables, write-through read data and clear sweep
module jram_sp #(
   parameter int          AW           = 8,
   parameter int          DW           = 16,
   parameter bit          CLR_ON_RESET = 1'b1,
   parameter logic [DW-1:0] INIT_VALUE = '0
) (
   input logic        sys_clk,
   input logic        resetl,
   jram_sp_if.slave   bus
);
   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << AW;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;
   localparam logic [0:0] ST_RESET = CLR_ON_RESET ? ST_CLEAR : ST_READY;

   logic [DW-1:0] mem_q [DEPTH];

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] z_out_q, z_out_d;
   logic          z_oe_q, z_oe_d;
   logic          busy_q, busy_d;

   logic [DW-1:0] rd_word;
   logic [DW-1:0] merged;
   logic          wr_en;
   logic          clr_we;

   always_comb begin
      rd_word = mem_q[bus.a];
      merged  = rd_word;
      for (int k = 0; k < NB; k++) begin
         if (bus.be[k]) merged[8*k +: 8] = bus.z_in[8*k +: 8];
      end
      wr_en  = (state_q == ST_READY) && !bus.clr && !bus.cen && !bus.rw;
      // the array must not be touched while reset is held, even though the FSM sits in CLEAR
      clr_we = (state_q == ST_CLEAR) && resetl;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      z_out_d = z_out_q;
      z_oe_d  = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) begin
               state_d = ST_READY;
               busy_d  = 1'b0;
            end
         end
         ST_READY: begin
            if (bus.clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else if (!bus.cen) begin
               z_out_d = bus.rw ? rd_word : merged;
               z_oe_d  = bus.rw;
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         z_out_q <= '0;
         z_oe_q  <= 1'b0;
         busy_q  <= CLR_ON_RESET;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         z_out_q <= z_out_d;
         z_oe_q  <= z_oe_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (clr_we) begin
         mem_q[cnt_q] <= INIT_VALUE;
      end else if (wr_en) begin
         for (int k = 0; k < NB; k++) begin
            if (bus.be[k]) mem_q[bus.a][8*k +: 8] <= bus.z_in[8*k +: 8];
         end
      end
   end

   assign bus.z_out = z_out_q;
   assign bus.z_oe  = {DW{z_oe_q}};
   assign bus.busy  = busy_q;
endmodule
